// File: rtl/soc_boot_pkg.sv
// Shared types and helpers for the boot sequencer.
package soc_boot_pkg;

    localparam int BOOT_STATE_W = 3;

    typedef enum logic [BOOT_STATE_W-1:0] {
        HOLD,
        LOAD,
        RELEASE,
        RUN,
        HALT
    } boot_state_t;

    // Bits needed to hold n-1 for a counter that counts n cycles.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/boot_cycle_counter.sv
// Loadable down-counter with zero flag; resets to and re-loads LOAD_VAL, saturates at zero.
module boot_cycle_counter #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] LOAD_VAL = '0
) (
    input  logic Clk_Core,
    input  logic Rst_Core_N,
    input  logic load,
    input  logic dec,
    output logic zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            count <= LOAD_VAL;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/soc_boot_ctrl.sv
// Boot sequencer: holds the core in reset, streams NUM_WORDS words into instruction memory, then releases it.
// Optional run-cycle limit with sticky Halt is enabled by defining BOOT_RUN_LIMIT_EN.
//
//   state   | meaning
//   HOLD    | core reset asserted, hold counter running down
//   LOAD    | accepting source words, writing instruction memory
//   RELEASE | one cycle for the final write to land, core still in reset
//   RUN     | core released, Boot_Done high
//   HALT    | run limit reached, core back in reset, Halt high
module soc_boot_ctrl
    import soc_boot_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 8,
    parameter int NUM_WORDS       = 8,
    parameter int BASE_ADDR       = 0,
    parameter int RST_HOLD_CYCLES = 10,
    parameter int RUN_CYCLES      = 10
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core_N,
    input  logic                  Src_Valid,
    input  logic [DATA_WIDTH-1:0] Src_Data,
    output logic                  Src_Ready,
    input  logic                  Reload,
    output logic                  Imem_We,
    output logic [ADDR_WIDTH-1:0] Imem_Addr,
    output logic [DATA_WIDTH-1:0] Imem_Wdata,
    output logic                  Core_Rst_N,
    output logic                  Boot_Done,
    output logic                  Halt
);

    localparam int                    WCNT_W    = ADDR_WIDTH + 1;
    localparam int                    HOLD_W    = cnt_width(RST_HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]     HOLD_LOAD = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [WCNT_W-1:0]     NUM_W     = WCNT_W'(NUM_WORDS);
    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);

    if (RST_HOLD_CYCLES < 1 || RUN_CYCLES < 1 || NUM_WORDS < 0 || NUM_WORDS > (2 ** ADDR_WIDTH)) begin : g_param_check
        $error("soc_boot_ctrl: parameter out of range");
    end

    boot_state_t           state, state_nxt;
    logic [WCNT_W-1:0]     word_cnt, word_cnt_nxt, word_cnt_inc;
    logic                  src_ready_q, imem_we_q, core_rst_n_q, boot_done_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [DATA_WIDTH-1:0] imem_wdata_q;
    logic                  handshake, rearm, hold_zero;

    assign handshake    = Src_Valid & src_ready_q;
    assign rearm        = Reload && ((state == RUN) || (state == HALT));
    assign word_cnt_inc = word_cnt + WCNT_W'(1);

    boot_cycle_counter #(.WIDTH(HOLD_W), .LOAD_VAL(HOLD_LOAD)) u_hold_cnt (
        .Clk_Core  (Clk_Core),
        .Rst_Core_N(Rst_Core_N),
        .load      (rearm),
        .dec       (state == HOLD),
        .zero      (hold_zero)
    );

`ifdef BOOT_RUN_LIMIT_EN
    localparam int                RUN_W    = cnt_width(RUN_CYCLES);
    localparam logic [RUN_W-1:0]  RUN_LOAD = RUN_W'(RUN_CYCLES - 1);

    logic run_zero;
    logic halt_q;

    // Every RUN entry comes through RELEASE, so loading there arms the limit on entry.
    boot_cycle_counter #(.WIDTH(RUN_W), .LOAD_VAL(RUN_LOAD)) u_run_cnt (
        .Clk_Core  (Clk_Core),
        .Rst_Core_N(Rst_Core_N),
        .load      (state == RELEASE),
        .dec       (state == RUN),
        .zero      (run_zero)
    );

    assign Halt = halt_q;
`else
    assign Halt = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        case (state)
            HOLD: begin
                if (hold_zero) begin
                    state_nxt = (NUM_WORDS == 0) ? RELEASE : LOAD;
                end
            end
            LOAD: begin
                if (handshake) begin
                    word_cnt_nxt = word_cnt_inc;
                    if (word_cnt_inc == NUM_W) begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RELEASE: state_nxt = RUN;
            RUN: begin
                if (rearm) begin
                    state_nxt = HOLD;
`ifdef BOOT_RUN_LIMIT_EN
                end else if (run_zero) begin
                    state_nxt = HALT;
`endif
                end
            end
            HALT: begin
                if (rearm) begin
                    state_nxt = HOLD;
                end
            end
            default: state_nxt = HOLD;
        endcase
        if (rearm) begin
            word_cnt_nxt = '0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge Clk_Core) begin
        if (!Rst_Core_N) begin
            state        <= HOLD;
            word_cnt     <= '0;
            src_ready_q  <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_n_q <= 1'b0;
            boot_done_q  <= 1'b0;
`ifdef BOOT_RUN_LIMIT_EN
            halt_q       <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            word_cnt     <= word_cnt_nxt;
            src_ready_q  <= (state_nxt == LOAD);
            imem_we_q    <= handshake;
            if (handshake) begin
                imem_addr_q  <= BASE + word_cnt[ADDR_WIDTH-1:0];
                imem_wdata_q <= Src_Data;
            end
            core_rst_n_q <= (state_nxt == RUN);
            boot_done_q  <= (state_nxt == RUN);
`ifdef BOOT_RUN_LIMIT_EN
            halt_q       <= (state_nxt == HALT);
`endif
        end
    end

    assign Src_Ready  = src_ready_q;
    assign Imem_We    = imem_we_q;
    assign Imem_Addr  = imem_addr_q;
    assign Imem_Wdata = imem_wdata_q;
    assign Core_Rst_N = core_rst_n_q;
    assign Boot_Done  = boot_done_q;

endmodule

// File: tb/tb_soc_boot_ctrl.sv
// Self-checking bench for soc_boot_ctrl: scoreboard of expected memory writes plus per-scenario timing checks.
module tb_soc_boot_ctrl;

    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int NW   = 8;
    localparam int BASE = 0;
    localparam int HOLD = 10;

    logic          Clk_Core   = 1'b0;
    logic          Rst_Core_N = 1'b0;
    logic          Src_Valid  = 1'b0;
    logic [DW-1:0] Src_Data   = '0;
    logic          Reload     = 1'b0;

    logic          Src_Ready, Imem_We, Core_Rst_N, Boot_Done, Halt;
    logic [AW-1:0] Imem_Addr;
    logic [DW-1:0] Imem_Wdata;

    logic          z_Src_Ready, z_Imem_We, z_Core_Rst_N, z_Boot_Done, z_Halt;
    logic [AW-1:0] z_Imem_Addr;
    logic [DW-1:0] z_Imem_Wdata;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;

    logic [DW-1:0] words [NW] = '{32'h3e800093, 32'h7d008113, 32'hc1810193, 32'h83018213,
                                  32'h3e820293, 32'h00000013, 32'h00128293, 32'h00430313};

    always #5 Clk_Core = ~Clk_Core;

    soc_boot_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(NW), .BASE_ADDR(BASE),
        .RST_HOLD_CYCLES(HOLD), .RUN_CYCLES(10)
    ) dut (
        .Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N), .Src_Valid(Src_Valid), .Src_Data(Src_Data),
        .Src_Ready(Src_Ready), .Reload(Reload), .Imem_We(Imem_We), .Imem_Addr(Imem_Addr),
        .Imem_Wdata(Imem_Wdata), .Core_Rst_N(Core_Rst_N), .Boot_Done(Boot_Done), .Halt(Halt)
    );

    soc_boot_ctrl #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WORDS(0), .BASE_ADDR(BASE),
        .RST_HOLD_CYCLES(HOLD), .RUN_CYCLES(10)
    ) dut_z (
        .Clk_Core(Clk_Core), .Rst_Core_N(Rst_Core_N), .Src_Valid(Src_Valid), .Src_Data(Src_Data),
        .Src_Ready(z_Src_Ready), .Reload(Reload), .Imem_We(z_Imem_We), .Imem_Addr(z_Imem_Addr),
        .Imem_Wdata(z_Imem_Wdata), .Core_Rst_N(z_Core_Rst_N), .Boot_Done(z_Boot_Done), .Halt(z_Halt)
    );

    // Write monitor: every memory write must match the oldest predicted handshake.
    always @(negedge Clk_Core) begin
        if (Imem_We === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL imem_write unexpected: addr=%0h data=%h, expected no write", Imem_Addr, Imem_Wdata);
            end else begin
                mon_e = exp_q.pop_front();
                if (Imem_Addr !== mon_e.addr || Imem_Wdata !== mon_e.data) begin
                    fails++;
                    $display("FAIL imem_write: got addr=%0h data=%h, expected addr=%0h data=%h",
                             Imem_Addr, Imem_Wdata, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk_Core);
        #1;
    endtask

    task automatic do_reset();
        Rst_Core_N = 1'b0;
        Src_Valid  = 1'b0;
        Reload     = 1'b0;
        tick();
        tick();
    endtask

    function automatic bit valid_at(input int pat, input int cyc);
        if (pat == 0) return 1'b1;
        return (cyc % 4 == 0) || (cyc % 4 == 3);
    endfunction

    // Starts on the first HOLD cycle; returns on the first RUN cycle (or after stop_at handshakes).
    task automatic boot_sequence(input int pat, input int reload_at, input logic [DW-1:0] salt, input int stop_at);
        int cyc = 0;
        int cnt = 0;
        bit pulsed = 1'b0;
        bit v;
        for (int i = 0; i < HOLD; i++) begin
            tests++;
            if (Core_Rst_N !== 1'b0 || Src_Ready !== 1'b0 || Boot_Done !== 1'b0 || Halt !== 1'b0) begin
                fails++;
                $display("FAIL hold_phase cyc=%0d: core_rst_n=%b src_ready=%b boot_done=%b halt=%b, expected all 0",
                         i, Core_Rst_N, Src_Ready, Boot_Done, Halt);
            end
            Src_Valid = valid_at(pat, cyc);
            Src_Data  = $urandom;
            tick();
            cyc++;
        end
        while (cnt < stop_at && cyc < 200) begin
            tests++;
            if (Src_Ready !== 1'b1 || Core_Rst_N !== 1'b0 || Boot_Done !== 1'b0) begin
                fails++;
                $display("FAIL load_phase cyc=%0d word=%0d: src_ready=%b core_rst_n=%b boot_done=%b, expected 1 0 0",
                         cyc, cnt, Src_Ready, Core_Rst_N, Boot_Done);
            end
            v         = valid_at(pat, cyc);
            Src_Valid = v;
            Reload    = 1'b0;
            if (!pulsed && reload_at >= 0 && cnt == reload_at) begin
                Reload = 1'b1;
                pulsed = 1'b1;
            end
            if (v && Src_Ready === 1'b1) begin
                Src_Data = words[cnt] ^ salt;
                exp_q.push_back(wr_t'{addr: AW'(BASE + cnt), data: words[cnt] ^ salt});
                cnt++;
            end else begin
                Src_Data = $urandom;
            end
            tick();
            cyc++;
        end
        Src_Valid = 1'b0;
        Reload    = 1'b0;
        tests++;
        if (cnt != stop_at) begin
            fails++;
            $display("FAIL load_timeout: accepted %0d words, expected %0d", cnt, stop_at);
        end
        if (stop_at == NW) begin
            tests++;
            if (Src_Ready !== 1'b0 || Core_Rst_N !== 1'b0 || Boot_Done !== 1'b0) begin
                fails++;
                $display("FAIL release_phase: src_ready=%b core_rst_n=%b boot_done=%b, expected 0 0 0",
                         Src_Ready, Core_Rst_N, Boot_Done);
            end
            tick();
            tests++;
            if (Core_Rst_N !== 1'b1 || Boot_Done !== 1'b1 || Src_Ready !== 1'b0 || Imem_We !== 1'b0 || Halt !== 1'b0) begin
                fails++;
                $display("FAIL run_entry: core_rst_n=%b boot_done=%b src_ready=%b imem_we=%b halt=%b, expected 1 1 0 0 0",
                         Core_Rst_N, Boot_Done, Src_Ready, Imem_We, Halt);
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({Src_Ready, Imem_We, Imem_Addr, Imem_Wdata, Core_Rst_N, Boot_Done, Halt} !== '0) begin
            fails++;
            $display("FAIL reset_values: ready=%b we=%b addr=%0h wdata=%h core_rst_n=%b done=%b halt=%b, expected all 0",
                     Src_Ready, Imem_We, Imem_Addr, Imem_Wdata, Core_Rst_N, Boot_Done, Halt);
        end
    endtask

    task automatic test_boot_basic();
        Rst_Core_N = 1'b1;
        boot_sequence(0, -1, '0, NW);
    endtask

    task automatic test_reload();
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (Core_Rst_N !== 1'b1 || Boot_Done !== 1'b1) begin
                fails++;
                $display("FAIL run_stable: core_rst_n=%b boot_done=%b, expected 1 1", Core_Rst_N, Boot_Done);
            end
        end
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
        tests++;
        if (Core_Rst_N !== 1'b0 || Boot_Done !== 1'b0) begin
            fails++;
            $display("FAIL reload_in_run: core_rst_n=%b boot_done=%b, expected 0 0", Core_Rst_N, Boot_Done);
        end
        boot_sequence(0, 2, 32'hA5A5_0000, NW);
    endtask

    task automatic test_valid_toggle();
        do_reset();
        Rst_Core_N = 1'b1;
        boot_sequence(1, -1, 32'h0000_FFFF, NW);
    endtask

    task automatic test_num_words_zero();
        bit exp_run;
        do_reset();
        Rst_Core_N = 1'b1;
        for (int i = 0; i < HOLD + 4; i++) begin
            exp_run = (i >= HOLD + 1);
            tests++;
            if (z_Src_Ready !== 1'b0 || z_Imem_We !== 1'b0 || z_Imem_Addr !== '0 || z_Imem_Wdata !== '0 ||
                z_Halt !== 1'b0 || z_Core_Rst_N !== exp_run || z_Boot_Done !== exp_run) begin
                fails++;
                $display("FAIL zero_words cyc=%0d: ready=%b we=%b core_rst_n=%b done=%b halt=%b, expected 0 0 %b %b 0",
                         i, z_Src_Ready, z_Imem_We, z_Core_Rst_N, z_Boot_Done, z_Halt, exp_run, exp_run);
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        Rst_Core_N = 1'b1;
        boot_sequence(0, -1, 32'h1234_0000, 4);
        Rst_Core_N = 1'b0;
        tick();
        tests++;
        if ({Src_Ready, Imem_We, Imem_Addr, Imem_Wdata, Core_Rst_N, Boot_Done, Halt} !== '0) begin
            fails++;
            $display("FAIL mid_load_reset: ready=%b we=%b addr=%0h wdata=%h core_rst_n=%b done=%b halt=%b, expected all 0",
                     Src_Ready, Imem_We, Imem_Addr, Imem_Wdata, Core_Rst_N, Boot_Done, Halt);
        end
        Rst_Core_N = 1'b1;
        boot_sequence(0, -1, 32'h0BAD_0000, NW);
    endtask

`ifdef BOOT_RUN_LIMIT_EN
    task automatic test_run_limit();
        for (int i = 1; i < 10; i++) begin
            tick();
            tests++;
            if (Core_Rst_N !== 1'b1 || Halt !== 1'b0) begin
                fails++;
                $display("FAIL run_before_limit r=%0d: core_rst_n=%b halt=%b, expected 1 0", i, Core_Rst_N, Halt);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (Halt !== 1'b1 || Core_Rst_N !== 1'b0 || Boot_Done !== 1'b0) begin
                fails++;
                $display("FAIL halt_sticky k=%0d: halt=%b core_rst_n=%b done=%b, expected 1 0 0",
                         i, Halt, Core_Rst_N, Boot_Done);
            end
        end
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
        tests++;
        if (Halt !== 1'b0 || Core_Rst_N !== 1'b0) begin
            fails++;
            $display("FAIL reload_from_halt: halt=%b core_rst_n=%b, expected 0 0", Halt, Core_Rst_N);
        end
        boot_sequence(0, -1, 32'h5555_0000, NW);
        for (int i = 1; i < 10; i++) tick();
        Reload = 1'b1;
        tick();
        Reload = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tests++;
            if (Halt !== 1'b0 || Core_Rst_N !== 1'b0 || Boot_Done !== 1'b0) begin
                fails++;
                $display("FAIL reload_at_expiry k=%0d: halt=%b core_rst_n=%b done=%b, expected 0 0 0",
                         i, Halt, Core_Rst_N, Boot_Done);
            end
            if (i == 0) tick();
        end
        do_reset();
    endtask
`else
    task automatic test_run_persist();
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if (Halt !== 1'b0 || Core_Rst_N !== 1'b1 || Boot_Done !== 1'b1) begin
                fails++;
                $display("FAIL run_persist k=%0d: halt=%b core_rst_n=%b done=%b, expected 0 1 1",
                         i, Halt, Core_Rst_N, Boot_Done);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot_basic();
        test_reload();
        test_valid_toggle();
        test_num_words_zero();
        test_reset_mid_load();
`ifdef BOOT_RUN_LIMIT_EN
        test_run_limit();
`else
        test_run_persist();
`endif
        tick();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL pending_writes: %0d predicted writes never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
